// File: rtl/mm_host_bridge.sv
// mm_host_bridge: single-outstanding host-to-decoder bridge with read timeout and error response
module mm_host_bridge #(
  parameter int          TIMEOUT  = 64,
  parameter logic [63:0] ERR_DATA = 64'hDEAD_DEAD_DEAD_DEAD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iHOST_REQ_V,
  output logic        oHOST_REQ_RDY,
  input  logic        iHOST_REQ_WR,
  input  logic [16:0] iHOST_ADDR,
  input  logic [63:0] iHOST_WR_DATA,
  output logic        oHOST_RSP_V,
  output logic [63:0] oHOST_RSP_DATA,
  output logic        oHOST_RSP_ERR,
  output logic        oMM_WR_EN,
  output logic        oMM_RD_EN,
  output logic [16:0] oMM_ADDR,
  output logic [63:0] oMM_WR_DATA,
  input  logic [63:0] iMM_RD_DATA,
  input  logic        iMM_RD_DATA_V,
  output logic [15:0] oTIMEOUT_CNT
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t      r_state;
  logic        r_wr_en, r_rd_en, r_rsp_v, r_rsp_err;
  logic [16:0] r_addr;
  logic [63:0] r_wdata, r_rsp_data;
  logic [15:0] r_wait, r_tcnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rsp_v    <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rsp_data <= '0;
      r_wait     <= '0;
      r_tcnt     <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_rsp_v <= 1'b0;
      case (r_state)
        IDLE: if (iHOST_REQ_V) begin
          r_addr  <= iHOST_ADDR;
          r_wdata <= iHOST_WR_DATA;
          r_wr_en <= iHOST_REQ_WR;
          r_rd_en <= !iHOST_REQ_WR;
          r_state <= ISSUE;
        end
        ISSUE: begin
          r_state <= r_wr_en ? IDLE : WAIT;
          r_wait  <= '0;
        end
        WAIT: if (iMM_RD_DATA_V) begin
          // data beats the timeout when both land on the final wait cycle
          r_rsp_v    <= 1'b1;
          r_rsp_data <= iMM_RD_DATA;
          r_rsp_err  <= 1'b0;
          r_state    <= IDLE;
        end else if (r_wait == 16'(TIMEOUT - 1)) begin
          r_rsp_v    <= 1'b1;
          r_rsp_data <= ERR_DATA;
          r_rsp_err  <= 1'b1;
          r_tcnt     <= r_tcnt + {15'd0, r_tcnt != 16'hFFFF};
          r_state    <= IDLE;
        end else begin
          r_wait <= r_wait + 16'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign oHOST_REQ_RDY  = r_state == IDLE;
  assign oHOST_RSP_V    = r_rsp_v;
  assign oHOST_RSP_DATA = r_rsp_data;
  assign oHOST_RSP_ERR  = r_rsp_err;
  assign oMM_WR_EN      = r_wr_en;
  assign oMM_RD_EN      = r_rd_en;
  assign oMM_ADDR       = r_addr;
  assign oMM_WR_DATA    = r_wdata;
  assign oTIMEOUT_CNT   = r_tcnt;
endmodule

// File: tb/tb_mm_host_bridge.sv
// tb_mm_host_bridge: directed checks of mm_host_bridge with TIMEOUT=4
module tb_mm_host_bridge;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_v = 1'b0, req_wr = 1'b0, rd_v = 1'b0;
  logic [16:0] addr = '0;
  logic [63:0] wdata = '0, rdata = '0;
  logic        rdy, rsp_v, rsp_err, wr_en, rd_en;
  logic [63:0] rsp_data, mm_wdata;
  logic [16:0] mm_addr;
  logic [15:0] tcnt;
  int          checks = 0, errors = 0, n_rsp = 0;
  mm_host_bridge #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .iHOST_REQ_V(req_v), .oHOST_REQ_RDY(rdy), .iHOST_REQ_WR(req_wr),
    .iHOST_ADDR(addr), .iHOST_WR_DATA(wdata),
    .oHOST_RSP_V(rsp_v), .oHOST_RSP_DATA(rsp_data), .oHOST_RSP_ERR(rsp_err),
    .oMM_WR_EN(wr_en), .oMM_RD_EN(rd_en), .oMM_ADDR(mm_addr), .oMM_WR_DATA(mm_wdata),
    .iMM_RD_DATA(rdata), .iMM_RD_DATA_V(rd_v), .oTIMEOUT_CNT(tcnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (rsp_v) n_rsp++;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    step(); step();
    check("rst_rdy", rdy, 1);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rsp_v", rsp_v, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_addr", mm_addr, 0);
    check("rst_wdata", mm_wdata, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_tcnt", tcnt, 0);
    rst_n = 1'b1;
    // read of 0x10, data two cycles after strobe
    req_v = 1'b1; req_wr = 1'b0; addr = 17'h00010;
    step(); req_v = 1'b0;
    check("rd_strobe", rd_en, 1);
    check("rd_no_wr", wr_en, 0);
    check("rd_addr", mm_addr, 17'h00010);
    check("rd_rdy_issue", rdy, 0);
    step();
    check("rd_strobe_end", rd_en, 0);
    check("rd_rdy_wait", rdy, 0);
    step();
    rd_v = 1'b1; rdata = 64'h1234_5678_9ABC_DEF0;
    check("rd_no_rsp_yet", rsp_v, 0);
    step(); rd_v = 1'b0;
    check("rd_rsp_v", rsp_v, 1);
    check("rd_rsp_data", rsp_data, 64'h1234_5678_9ABC_DEF0);
    check("rd_rsp_err", rsp_err, 0);
    check("rd_rdy_back", rdy, 1);
    step();
    check("rd_rsp_pulse", rsp_v, 0);
    check("rd_rsp_hold", rsp_data, 64'h1234_5678_9ABC_DEF0);
    check("rd_rsp_count", n_rsp, 1);
    // write of 0x100
    req_v = 1'b1; req_wr = 1'b1; addr = 17'h00100; wdata = 64'hA5;
    step(); req_v = 1'b0; req_wr = 1'b0;
    check("wr_strobe", wr_en, 1);
    check("wr_no_rd", rd_en, 0);
    check("wr_addr", mm_addr, 17'h00100);
    check("wr_data", mm_wdata, 64'hA5);
    check("wr_rdy_issue", rdy, 0);
    step();
    check("wr_rdy_back", rdy, 1);
    check("wr_strobe_end", wr_en, 0);
    check("wr_addr_hold", mm_addr, 17'h00100);
    step();
    check("wr_no_rsp", n_rsp, 1);
    // read timeout: response 5 cycles after strobe
    req_v = 1'b1; addr = 17'h00020;
    step(); req_v = 1'b0;
    check("to_strobe", rd_en, 1);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("to_no_rsp", rsp_v, 0);
    end
    step();
    check("to_rsp_v", rsp_v, 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_data", rsp_data, 64'hDEAD_DEAD_DEAD_DEAD);
    check("to_tcnt", tcnt, 1);
    step();
    check("to_rsp_pulse", rsp_v, 0);
    check("to_err_hold", rsp_err, 1);
    // data on the final wait cycle wins
    req_v = 1'b1; addr = 17'h00030;
    step(); req_v = 1'b0;
    check("race_strobe", rd_en, 1);
    step(); step(); step(); step();
    rd_v = 1'b1; rdata = 64'h55;
    check("race_no_rsp_yet", rsp_v, 0);
    step();
    rdata = 64'h66;
    check("race_rsp_v", rsp_v, 1);
    check("race_rsp_err", rsp_err, 0);
    check("race_rsp_data", rsp_data, 64'h55);
    check("race_tcnt", tcnt, 1);
    step();
    check("stray_no_rsp", rsp_v, 0);
    check("stray_rdy", rdy, 1);
    step(); rd_v = 1'b0;
    check("stray_no_rsp2", rsp_v, 0);
    check("stray_data_hold", rsp_data, 64'h55);
    check("stray_count", n_rsp, 3);
    // reset during WAIT
    req_v = 1'b1; addr = 17'h00040;
    step(); req_v = 1'b0;
    step(); step();
    check("rw_in_wait", rdy, 0);
    rst_n = 1'b0;
    step();
    check("rw_rdy", rdy, 1);
    check("rw_rsp_v", rsp_v, 0);
    check("rw_rsp_err", rsp_err, 0);
    check("rw_rsp_data", rsp_data, 0);
    check("rw_rd_en", rd_en, 0);
    check("rw_addr", mm_addr, 0);
    check("rw_tcnt", tcnt, 0);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b1;
    check("rw_rdy_release", rdy, 1);
    step(); step(); step(); step(); step(); step();
    check("rw_no_rsp", n_rsp, 3);
    check("rw_tcnt_after", tcnt, 0);
    // back-to-back with request valid held high
    req_v = 1'b1; addr = 17'h00050;
    step();
    check("b2b_strobe1", rd_en, 1);
    check("b2b_rdy_issue", rdy, 0);
    step();
    check("b2b_rdy_wait", rdy, 0);
    rd_v = 1'b1; rdata = 64'h77;
    step(); rd_v = 1'b0; addr = 17'h00060;
    check("b2b_rsp_v", rsp_v, 1);
    check("b2b_rsp_data", rsp_data, 64'h77);
    check("b2b_rdy_rsp", rdy, 1);
    step(); req_v = 1'b0;
    check("b2b_strobe2", rd_en, 1);
    check("b2b_addr2", mm_addr, 17'h00060);
    check("b2b_rsp_end", rsp_v, 0);
    check("b2b_count", n_rsp, 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mm_host_bridge.md
MM_HOST_BRIDGE -- requirements
Module: mm_host_bridge

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 64, meaning the number of cycles to wait for read data before reporting an error (legal range 2..65535).
REQ-002 The block SHALL have parameter ERR_DATA, default 64'hDEAD_DEAD_DEAD_DEAD, meaning the data returned on a read timeout.
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port iHOST_REQ_V  input  1  host request valid.
REQ-006 The block SHALL have port oHOST_REQ_RDY  output  1  bridge can accept a request.
REQ-007 The block SHALL have port iHOST_REQ_WR  input  1  1 = write, 0 = read.
REQ-008 The block SHALL have port iHOST_ADDR  input  17  request address.
REQ-009 The block SHALL have port iHOST_WR_DATA  input  64  write data.
REQ-010 The block SHALL have port oHOST_RSP_V  output  1  read response valid, one-cycle pulse.
REQ-011 The block SHALL have port oHOST_RSP_DATA  output  64  read response data.
REQ-012 The block SHALL have port oHOST_RSP_ERR  output  1  read timed out.
REQ-013 The block SHALL have port oMM_WR_EN  output  1  write strobe to the global address decoder.
REQ-014 The block SHALL have port oMM_RD_EN  output  1  read strobe to the global address decoder.
REQ-015 The block SHALL have port oMM_ADDR  output  17  address to the decoder.
REQ-016 The block SHALL have port oMM_WR_DATA  output  64  write data to the decoder.
REQ-017 The block SHALL have port iMM_RD_DATA  input  64  read data from the decoder.
REQ-018 The block SHALL have port iMM_RD_DATA_V  input  1  read data valid from the decoder.
REQ-019 The block SHALL have port oTIMEOUT_CNT  output  16  count of read timeouts, saturating.

Function
REQ-020 The block SHALL implement an FSM with states IDLE, ISSUE and WAIT; oHOST_REQ_RDY SHALL be 1 only in IDLE.
REQ-021 A request SHALL be accepted on a rising edge where iHOST_REQ_V=1 and oHOST_REQ_RDY=1; on acceptance, address, write data and the write flag SHALL be registered and the FSM SHALL move to ISSUE.
REQ-022 In ISSUE, exactly one of oMM_WR_EN or oMM_RD_EN SHALL be high for exactly one cycle, with oMM_ADDR/oMM_WR_DATA driving the registered values; this cycle SHALL be the cycle immediately after acceptance.
REQ-023 oMM_ADDR and oMM_WR_DATA SHALL hold their last values outside ISSUE; the strobes SHALL be 0 outside ISSUE.
REQ-024 After a write ISSUE, the FSM SHALL return to IDLE; writes SHALL generate no host response, giving one write per 2 cycles maximum.
REQ-025 After a read ISSUE, the FSM SHALL enter WAIT with a wait counter cleared to 0; the counter SHALL increment in each WAIT cycle that does not see iMM_RD_DATA_V.
REQ-026 In WAIT, when iMM_RD_DATA_V=1 is sampled, the next cycle SHALL have oHOST_RSP_V=1, oHOST_RSP_DATA=the sampled iMM_RD_DATA and oHOST_RSP_ERR=0, and the FSM SHALL return to IDLE.
REQ-027 In WAIT, when the wait counter equals TIMEOUT-1 and iMM_RD_DATA_V=0, the next cycle SHALL have oHOST_RSP_V=1, oHOST_RSP_DATA=ERR_DATA and oHOST_RSP_ERR=1; oTIMEOUT_CNT SHALL increment, saturating at 16'hFFFF, and the FSM SHALL return to IDLE.
REQ-028 If iMM_RD_DATA_V=1 in the same cycle the counter reaches TIMEOUT-1, valid data SHALL win and no timeout SHALL be counted.
REQ-029 iMM_RD_DATA_V asserted in IDLE or ISSUE (stray or late data) SHALL be ignored: no response is produced and the FSM state is unchanged.
REQ-030 oHOST_RSP_V SHALL be a single-cycle pulse; oHOST_RSP_DATA/ERR SHALL hold their values until the next response.
REQ-031 A request arriving in the same cycle a response pulses SHALL be accepted, since the FSM is in IDLE in that cycle.

Reset
REQ-032 While rst_n=0 at a rising edge, the FSM SHALL go to IDLE, and oMM_WR_EN, oMM_RD_EN, oHOST_RSP_V and oHOST_RSP_ERR SHALL be 0; oMM_ADDR, oMM_WR_DATA, oHOST_RSP_DATA, oTIMEOUT_CNT and the wait counter SHALL be 0.
REQ-033 Reset asserted mid-transaction (ISSUE or WAIT) SHALL abort it with no strobe, response or timeout count; oHOST_REQ_RDY SHALL be 1 in the first cycle after rst_n rises.

Verification
REQ-034 The bench SHALL cover: a read of addr 17'h00010 with the decoder returning 64'h1234_5678_9ABC_DEF0 two cycles after the strobe -> one oMM_RD_EN pulse with oMM_ADDR=17'h00010, then one oHOST_RSP_V pulse with that data and ERR=0.
REQ-035 The bench SHALL cover: a write of addr 17'h00100 with data 64'hA5 -> one oMM_WR_EN pulse the cycle after acceptance, no oHOST_RSP_V, and RDY back to 1 the following cycle.
REQ-036 The bench SHALL cover: a read with TIMEOUT=4 and no iMM_RD_DATA_V -> RSP_V with ERR=1 and DATA=64'hDEAD_DEAD_DEAD_DEAD exactly 5 cycles after the strobe, and oTIMEOUT_CNT=1.
REQ-037 The bench SHALL cover: TIMEOUT=4 with data_v arriving on the final wait cycle -> RSP with ERR=0 and oTIMEOUT_CNT unchanged; a stray data_v in IDLE afterwards -> no RSP_V.
REQ-038 The bench SHALL cover: rst_n=0 asserted during WAIT -> no RSP_V at any time, all outputs 0 on the next edge, and RDY=1 in the first cycle after release.
REQ-039 The bench SHALL cover: back-to-back requests with iHOST_REQ_V held high -> RDY low in ISSUE and WAIT, and the next request accepted in the response cycle.
